sram_march_bist: RTL and testbench

Built-in self-test sequencer for the OpenRAM testchip SRAM macros. When started, it takes exclusive control of the shared port-0 bus (addr0/din0/web0/wmask0 plus one csb0 per macro) and runs a March C- variant on one selected macro. It compares read data against the expected pattern under a bit mask and reports pass/fail, the first failing address and data, and a saturating failure count. It sits between the testchip control logic and the SRAM port-0 bus mux, and drives the bus only while busy.

---
 rtl/sram_march_bist_if.sv | 17 +
 rtl/sram_march_bist.sv | 195 +++++++++++++++++++
 tb/tb_sram_march_bist.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_march_bist_if.sv
// Shared SRAM port-0 bus between the BIST sequencer (master) and the macro/mux side (slave).
interface sram_march_bist_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int WMASK_WIDTH = 4,
  parameter int NUM_SRAMS   = 16
);
  logic [NUM_SRAMS-1:0]   csb0;
  logic                   web0;
  logic [WMASK_WIDTH-1:0] wmask0;
  logic [ADDR_WIDTH-1:0]  addr0;
  logic [DATA_WIDTH-1:0]  din0;
  logic [DATA_WIDTH-1:0]  dout0;

  modport master (output csb0, web0, wmask0, addr0, din0, input dout0);
  modport slave  (input csb0, web0, wmask0, addr0, din0, output dout0);
endinterface

// File: rtl/sram_march_bist.sv
// March C- BIST sequencer for one selected OpenRAM macro on the shared port-0 bus.
// All outputs are registered; the bus is only driven active while a test is running.
module sram_march_bist #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int WMASK_WIDTH = 4,
  parameter int NUM_SRAMS   = 16,
  parameter int SEL_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [SEL_WIDTH-1:0]  sram_sel,
  input  logic [ADDR_WIDTH-1:0] addr_max,
  input  logic [DATA_WIDTH-1:0] pattern,
  input  logic [DATA_WIDTH-1:0] cmp_mask,
  sram_march_bist_if.master     bus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data
);

  typedef enum logic [3:0] {
    IDLE, M0_W, M1_R, M1_C, M1_W, M2_R, M2_C, M2_W, M3_R, M3_C, FIN
  } state_t;

  state_t                state_q, state_d;
  logic                  go_q, go_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] max_q, max_d;
  logic [DATA_WIDTH-1:0] pat_q, pat_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [NUM_SRAMS-1:0]  csb0_q, csb0_d;
  logic                  web0_q, web0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [7:0]            fail_count_q, fail_count_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;

  logic [NUM_SRAMS-1:0]  sel_onehot;
  logic                  at_top, at_bottom, sel_ok, active, is_cmp, mismatch;
  logic [DATA_WIDTH-1:0] expected;

  for (genvar gi = 0; gi < NUM_SRAMS; gi++) begin : g_sel
    assign sel_onehot[gi] = (int'(sel_q) == gi);
  end

  assign at_top    = (addr0_q == max_q);
  assign at_bottom = (addr0_q == '0);
  assign sel_ok    = (int'(sram_sel) < NUM_SRAMS);
  assign active    = !(state_q inside {IDLE, FIN});
  assign is_cmp    = state_q inside {M1_C, M2_C, M3_C};
  assign expected  = (state_q == M2_C) ? ~pat_q : pat_q;
  assign mismatch  = is_cmp && (|((bus.dout0 ^ expected) & mask_q));

  always_comb begin
    state_d      = state_q;
    go_d         = go_q;
    sel_d        = sel_q;
    max_d        = max_q;
    pat_d        = pat_q;
    mask_d       = mask_q;
    addr0_d      = addr0_q;
    din0_d       = din0_q;
    csb0_d       = '1;
    web0_d       = 1'b1;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    pass_d       = pass_q;
    fail_count_d = fail_count_q;
    fail_addr_d  = fail_addr_q;
    fail_data_d  = fail_data_q;

    if (mismatch) begin
      if (fail_count_q != 8'hFF) fail_count_d = fail_count_q + 8'd1;
      if (fail_count_q == 8'd0) begin
        fail_addr_d = addr0_q;
        fail_data_d = bus.dout0;
      end
    end

    // state_q names the bus cycle currently on the pins; state_d picks the next one
    case (state_q)
      M0_W: if (at_top) begin state_d = M1_R; addr0_d = '0; end
            else addr0_d = addr0_q + 1'b1;
      M1_R: state_d = M1_C;
      M1_C: state_d = M1_W;
      M1_W: if (at_top) begin state_d = M2_R; addr0_d = max_q; end
            else begin state_d = M1_R; addr0_d = addr0_q + 1'b1; end
      M2_R: state_d = M2_C;
      M2_C: state_d = M2_W;
      M2_W: if (at_bottom) begin state_d = M3_R; addr0_d = max_q; end
            else begin state_d = M2_R; addr0_d = addr0_q - 1'b1; end
      M3_R: state_d = M3_C;
      M3_C: if (at_bottom) state_d = FIN;
            else begin state_d = M3_R; addr0_d = addr0_q - 1'b1; end
      default: begin
        state_d = IDLE;
        if (go_q) begin
          state_d = M0_W;
          addr0_d = '0;
          go_d    = 1'b0;
        end else if (start && !abort) begin
          sel_d        = sram_sel;
          max_d        = addr_max;
          pat_d        = pattern;
          mask_d       = cmp_mask;
          fail_count_d = 8'd0;
          fail_addr_d  = '0;
          fail_data_d  = '0;
          pass_d       = 1'b0;
          if (sel_ok) go_d = 1'b1;
          else        done_d = 1'b1;
        end
      end
    endcase

    if (abort && (active || go_q)) begin
      state_d = IDLE;
      go_d    = 1'b0;
      pass_d  = 1'b0;
    end

    case (state_d)
      M0_W, M2_W: begin csb0_d = ~sel_onehot; web0_d = 1'b0; din0_d = pat_q;  end
      M1_W:       begin csb0_d = ~sel_onehot; web0_d = 1'b0; din0_d = ~pat_q; end
      M1_R, M2_R, M3_R: csb0_d = ~sel_onehot;
      FIN: begin
        done_d = 1'b1;
        pass_d = (fail_count_d == 8'd0);
      end
      default: ;
    endcase
    busy_d = !(state_d inside {IDLE, FIN});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      go_q         <= 1'b0;
      sel_q        <= '0;
      max_q        <= '0;
      pat_q        <= '0;
      mask_q       <= '0;
      csb0_q       <= '1;
      web0_q       <= 1'b1;
      addr0_q      <= '0;
      din0_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_count_q <= 8'd0;
      fail_addr_q  <= '0;
      fail_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      go_q         <= go_d;
      sel_q        <= sel_d;
      max_q        <= max_d;
      pat_q        <= pat_d;
      mask_q       <= mask_d;
      csb0_q       <= csb0_d;
      web0_q       <= web0_d;
      addr0_q      <= addr0_d;
      din0_q       <= din0_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_count_q <= fail_count_d;
      fail_addr_q  <= fail_addr_d;
      fail_data_q  <= fail_data_d;
    end
  end

  assign bus.csb0   = csb0_q;
  assign bus.web0   = web0_q;
  assign bus.wmask0 = '1;
  assign bus.addr0  = addr0_q;
  assign bus.din0   = din0_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_count = fail_count_q;
  assign fail_addr  = fail_addr_q;
  assign fail_data  = fail_data_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench for sram_march_bist with a behavioural one-cycle-latency SRAM on macro 1.
module tb_sram_march_bist;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort;
  logic [3:0]  sram_sel;
  logic [15:0] addr_max;
  logic [31:0] pattern, cmp_mask;
  logic        busy, done, pass;
  logic [7:0]  fail_count;
  logic [15:0] fail_addr;
  logic [31:0] fail_data;

  logic        fault_stuck, fault_all;
  logic [31:0] mem [0:255];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] csb_log  [0:40];
  logic        web_log  [0:40];
  logic [15:0] addr_log [0:40];
  logic [31:0] din_log  [0:40];
  logic        busy_log [0:40];
  logic        done_log [0:40];

  sram_march_bist_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .WMASK_WIDTH(4), .NUM_SRAMS(16)) bus ();

  sram_march_bist #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .WMASK_WIDTH(4), .NUM_SRAMS(16), .SEL_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .sram_sel(sram_sel), .addr_max(addr_max), .pattern(pattern), .cmp_mask(cmp_mask),
    .bus(bus.master),
    .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input logic [31:0] word, input logic [7:0] a);
    logic [31:0] r;
    r = word;
    if (fault_stuck && a == 8'd2) r[4] = 1'b0;
    if (fault_all) r = r ^ 32'h1;
    return r;
  endfunction

  // Macro 1: writes land at the edge, reads appear on dout0 one cycle later
  always @(posedge clk) begin
    if (bus.csb0[1] == 1'b0) begin
      if (!bus.web0) mem[bus.addr0[7:0]] <= bus.din0;
      else bus.dout0 <= model_read(mem[bus.addr0[7:0]], bus.addr0[7:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $error("FAIL wait_done timeout observed=%0d expected<=%0d", cycles, budget);
    end
  endtask

  task automatic launch(input logic [15:0] amax, input logic [31:0] pat, input logic [31:0] msk);
    sram_sel = 4'd1;
    addr_max = amax;
    pattern  = pat;
    cmp_mask = msk;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    int cyc;
    int busy_cnt;
    int done_cnt;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    sram_sel = 4'd0; addr_max = 16'd0; pattern = '0; cmp_mask = '1;
    fault_stuck = 1'b0; fault_all = 1'b0;
    bus.dout0 = '0;
    repeat (3) tick();

    check("rst_csb0",  64'(bus.csb0), 64'hFFFF);
    check("rst_web0",  64'(bus.web0), 64'h1);
    check("rst_wmask", 64'(bus.wmask0), 64'hF);
    check("rst_addr0", 64'(bus.addr0), 64'h0);
    check("rst_din0",  64'(bus.din0), 64'h0);
    check("rst_busy",  64'({busy, done, pass}), 64'h0);
    check("rst_fails", 64'({fail_count, fail_addr, fail_data}), 64'h0);
    reset = 1'b0;
    tick();

    // Good macro, N=4; a second start with another sel is pulsed during M0
    launch(16'd3, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
    busy_cnt = 0;
    for (int j = 1; j <= 38; j++) begin
      tick();
      csb_log[j] = bus.csb0;  web_log[j]  = bus.web0;
      addr_log[j] = bus.addr0; din_log[j] = bus.din0;
      busy_log[j] = busy;      done_log[j] = done;
      if (busy) busy_cnt++;
      if (j == 2) begin start = 1'b1; sram_sel = 4'd5; end
      if (j == 3) start = 1'b0;
    end
    $display("good run: busy_cycles=%0d pass=%0b fail_count=%0d", busy_cnt, pass, fail_count);
    check("c1_m0w",      64'({csb_log[1], web_log[1], addr_log[1], din_log[1]}), {15'd0, 16'hFFFD, 1'b0, 16'd0, 32'hA5A5_A5A5});
    check("c4_m0w_top",  64'({csb_log[4], web_log[4], addr_log[4]}), {31'd0, 16'hFFFD, 1'b0, 16'd3});
    check("c5_m1r",      64'({csb_log[5], web_log[5], addr_log[5]}), {31'd0, 16'hFFFD, 1'b1, 16'd0});
    check("c6_m1c",      64'({csb_log[6], web_log[6], addr_log[6]}), {31'd0, 16'hFFFF, 1'b1, 16'd0});
    check("c7_m1w",      64'({web_log[7], addr_log[7], din_log[7]}), {15'd0, 1'b0, 16'd0, 32'h5A5A_5A5A});
    check("c16_m1w_top", 64'({web_log[16], addr_log[16], din_log[16]}), {15'd0, 1'b0, 16'd3, 32'h5A5A_5A5A});
    check("c17_m2r",     64'({csb_log[17], web_log[17], addr_log[17]}), {31'd0, 16'hFFFD, 1'b1, 16'd3});
    check("c19_m2w",     64'({web_log[19], addr_log[19], din_log[19]}), {15'd0, 1'b0, 16'd3, 32'hA5A5_A5A5});
    check("c28_m2w_bot", 64'({web_log[28], addr_log[28]}), {47'd0, 1'b0, 16'd0});
    check("c29_m3r",     64'({csb_log[29], web_log[29], addr_log[29]}), {31'd0, 16'hFFFD, 1'b1, 16'd3});
    check("c36_m3c",     64'({csb_log[36], busy_log[36], done_log[36], addr_log[36]}), {30'd0, 16'hFFFF, 1'b1, 1'b0, 16'd0});
    check("c37_done",    64'({busy_log[37], done_log[37], csb_log[37], web_log[37]}), {45'd0, 1'b0, 1'b1, 16'hFFFF, 1'b1});
    check("c38_no_done", 64'(done_log[38]), 64'h0);
    check("busy_cycles", 64'(busy_cnt), 64'd36);
    check("good_pass",   64'({pass, fail_count}), {55'd0, 1'b1, 8'd0});

    // Stuck-at-0 on bit 4 of word 2 with a zero background
    fault_stuck = 1'b1;
    launch(16'd3, 32'h0, 32'hFFFF_FFFF);
    wait_done(60, cyc);
    $display("stuck run: cycles=%0d pass=%0b count=%0d addr=%0d data=%h", cyc, pass, fail_count, fail_addr, fail_data);
    check("stuck_pass",  64'(pass), 64'h0);
    check("stuck_count", 64'(fail_count), 64'd1);
    check("stuck_addr",  64'(fail_addr), 64'd2);
    check("stuck_data",  64'(fail_data), 64'hFFFF_FFEF);
    tick();

    // Same fault hidden by the compare mask
    launch(16'd3, 32'h0, 32'hFFFF_FFEF);
    wait_done(60, cyc);
    $display("masked run: cycles=%0d pass=%0b count=%0d", cyc, pass, fail_count);
    check("masked_pass", 64'({pass, fail_count, fail_addr}), {39'd0, 1'b1, 8'd0, 16'd0});
    fault_stuck = 1'b0;
    tick();

    // Every read wrong over 200 words: count saturates, first fail is M1 at word 0
    fault_all = 1'b1;
    launch(16'd199, 32'h1234_5678, 32'hFFFF_FFFF);
    wait_done(2000, cyc);
    $display("all-bad run: cycles=%0d count=%0d addr=%0d data=%h", cyc, fail_count, fail_addr, fail_data);
    check("sat_count", 64'(fail_count), 64'hFF);
    check("sat_addr",  64'(fail_addr), 64'd0);
    check("sat_data",  64'(fail_data), 64'h1234_5679);
    check("sat_pass",  64'(pass), 64'h0);
    fault_all = 1'b0;
    tick();

    // Abort in M2 after a recorded failure, then a clean rerun
    fault_stuck = 1'b1;
    launch(16'd3, 32'h0, 32'hFFFF_FFFF);
    for (int j = 1; j <= 23; j++) tick();
    check("pre_abort_count", 64'({busy, fail_count}), {55'd0, 1'b1, 8'd1});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    $display("abort: csb0=%h busy=%0b done=%0b", bus.csb0, busy, done);
    check("abort_bus",  64'({bus.csb0, bus.web0, busy, done}), {45'd0, 16'hFFFF, 1'b1, 1'b0, 1'b0});
    done_cnt = 0;
    for (int j = 0; j < 40; j++) begin
      tick();
      if (done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_pass",    64'({pass, busy}), 64'h0);
    fault_stuck = 1'b0;
    launch(16'd3, 32'h0, 32'hFFFF_FFFF);
    tick();
    check("rerun_c1", 64'({bus.csb0, bus.web0, bus.addr0, busy, fail_count}), {22'd0, 16'hFFFD, 1'b0, 16'd0, 1'b1, 8'd0});
    wait_done(60, cyc);
    $display("rerun: cycles=%0d pass=%0b count=%0d", cyc, pass, fail_count);
    check("rerun_pass", 64'({pass, fail_count}), {55'd0, 1'b1, 8'd0});
    tick();

    // Asynchronous reset between edges while in M1
    launch(16'd3, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
    for (int j = 1; j <= 5; j++) tick();
    check("pre_reset_busy", 64'({busy, bus.csb0}), {47'd0, 1'b1, 16'hFFFD});
    #2 reset = 1'b1;
    #1;
    $display("async reset: csb0=%h web0=%0b busy=%0b", bus.csb0, bus.web0, busy);
    check("areset_bus", 64'({bus.csb0, bus.web0, busy, bus.addr0}), {30'd0, 16'hFFFF, 1'b1, 1'b0, 16'd0});
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("post_reset_idle", 64'({busy, done, bus.csb0}), {46'd0, 1'b0, 1'b0, 16'hFFFF});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
